sd_cmd_serial_host: RTL and testbench

//  Serial end of the SD CMD-line channel: accepts a 40-bit command from sd_cmd_master over
//  the req/ack level handshake, serialises it with CRC7 and end bit onto the CMD pad,

---
 rtl/sd_cmd_serial_host_pkg.sv | 16 +
 rtl/sd_cmd_serial_host_crc7.sv | 14 +
 rtl/sd_cmd_serial_host.sv | 131 +++++++++++++
 tb/tb_sd_cmd_serial_host.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_serial_host_pkg.sv
// sd_cmd_serial_host_pkg: shared state encoding, status bit positions and response size codes
package sd_cmd_serial_host_pkg;
    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_DLY, S_TX, S_WAIT_RSP, S_RX, S_RX_CRC, S_NCC_WAIT, S_REPORT, S_REPORT_REL
    } state_t;
    localparam int ST_RSP_DONE = 6;
    localparam int ST_CRC_OK = 5;
    localparam int ST_TIMEOUT = 4;
    localparam int ST_END_ERR = 3;
    localparam int ST_BUSY = 0;
    localparam logic [6:0] RSP_NONE = 7'd0;
    localparam logic [6:0] RSP_SHORT = 7'd39;
    localparam logic [6:0] RSP_LONG = 7'd127;
    localparam int CMD_BITS = 40;
    localparam int TX_BITS = 48;
endpackage

// File: rtl/sd_cmd_serial_host_crc7.sv
// sd_cmd_crc7: serial CRC7 (x^7+x^3+1), one message bit per enabled cycle
module sd_cmd_crc7 (
    input  logic       CLK_PAD_IO,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_i,
    output logic [6:0] crc_o
);
    logic fb;
    assign fb = bit_i ^ crc_o[6];
    // shift the remainder, folding the feedback into taps x^3 and x^0
    always_ff @(posedge CLK_PAD_IO)
        crc_o <= clr ? '0 : en ? {crc_o[5:3], crc_o[2] ^ fb, crc_o[1:0], fb} : crc_o;
endmodule

// File: rtl/sd_cmd_serial_host.sv
// sd_cmd_serial_host: serialises SD commands onto the CMD pad and captures the card response
module sd_cmd_serial_host
    import sd_cmd_serial_host_pkg::*;
#(
    parameter int INIT_DELAY = 80,
    parameter int NCR_MAX = 64,
    parameter int NCC = 8
) (
    input  logic         CLK_PAD_IO,
    input  logic         RST_PAD_I,
    input  logic [15:0]  SETTING_I,
    input  logic [39:0]  CMD_I,
    input  logic         REQ_I,
    input  logic         ACK_I,
    input  logic         GO_IDLE_I,
    input  logic         CMD_DAT_I,
    output logic         REQ_O,
    output logic         ACK_O,
    output logic [127:0] CMD_O,
    output logic [7:0]   STATUS_O,
    output logic         CMD_OUT_O,
    output logic         CMD_OE_O
);
    localparam int CNT_A = INIT_DELAY > NCR_MAX ? INIT_DELAY : NCR_MAX;
    localparam int CNT_TOP = CNT_A > 136 ? CNT_A : 136;
    localparam int CW = $clog2(CNT_TOP + 1);

    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [39:0] cmd_q;
    logic [10:0] set_q;
    logic [6:0] size, crc;
    logic req_q, accept, go, crc_bad;
    logic crc_clr, crc_en, crc_bit;
    logic oe_d, out_d, ack_d, req_d;
    logic unused_set;

    assign unused_set = ^SETTING_I[15:11];
    assign size = set_q[6:0];
    assign go = GO_IDLE_I && state != S_INIT;
    assign accept = state == S_IDLE && REQ_I && !req_q && !GO_IDLE_I;

    sd_cmd_crc7 u_crc (
        .CLK_PAD_IO(CLK_PAD_IO),
        .clr       (crc_clr),
        .en        (crc_en),
        .bit_i     (crc_bit),
        .crc_o     (crc)
    );

    // state register
    always_ff @(posedge CLK_PAD_IO)
        state <= RST_PAD_I ? S_INIT : state_n;

    // next-state logic; abort to IDLE overrides every transition
    always_comb begin
        state_n = state;
        case (state)
            S_INIT:       if (cnt == CW'(INIT_DELAY - 1)) state_n = S_IDLE;
            S_IDLE:       if (accept) state_n = S_DLY;
            S_DLY:        if (cnt == CW'(set_q[10:8])) state_n = S_TX;
            S_TX:         if (cnt == CW'(TX_BITS - 1)) state_n = size == RSP_NONE ? S_NCC_WAIT : S_WAIT_RSP;
            S_WAIT_RSP:   if (!CMD_DAT_I) state_n = S_RX;
                          else if (cnt == CW'(NCR_MAX - 1)) state_n = S_NCC_WAIT;
            S_RX:         if (cnt == CW'(size - 7'd1)) state_n = S_RX_CRC;
            S_RX_CRC:     if (cnt == 7) state_n = S_NCC_WAIT;
            S_NCC_WAIT:   if (cnt == CW'(NCC - 1)) state_n = S_REPORT;
            S_REPORT:     if (ACK_I) state_n = S_REPORT_REL;
            S_REPORT_REL: if (!ACK_I) state_n = S_IDLE;
            default:      state_n = S_INIT;
        endcase
        if (go) state_n = S_IDLE;
    end

    // pad, handshake and CRC controls derived from the current state and bit counter
    always_comb begin
        ack_d = state == S_IDLE && state_n == S_IDLE;
        req_d = state == S_REPORT && !ACK_I && !go;
        oe_d = !go && (state == S_INIT || state == S_TX);
        out_d = state != S_TX ? 1'b1 : cnt < 40 ? cmd_q[6'(39 - cnt)] : cnt < 47 ? crc[3'(46 - cnt)] : 1'b1;
        crc_clr = RST_PAD_I || state == S_IDLE || (state == S_TX && cnt == CW'(TX_BITS - 1));
        crc_en = (state == S_TX && cnt < 40)
              || (state == S_WAIT_RSP && !CMD_DAT_I && size == RSP_SHORT)
              || (state == S_RX && (size == RSP_SHORT || cnt >= 7));
        crc_bit = state == S_TX ? cmd_q[6'(39 - cnt)] : CMD_DAT_I;
    end

    // bit counter, command latch, response capture, status and registered outputs
    always_ff @(posedge CLK_PAD_IO) begin
        if (RST_PAD_I) begin
            cnt <= '0;
            req_q <= 1'b0;
            cmd_q <= '0;
            set_q <= '0;
            crc_bad <= 1'b0;
            CMD_O <= '0;
            STATUS_O <= '0;
            REQ_O <= 1'b0;
            ACK_O <= 1'b0;
            CMD_OUT_O <= 1'b1;
            CMD_OE_O <= 1'b1;
        end else begin
            cnt <= state_n != state ? '0 : &cnt ? cnt : cnt + 1'b1;
            req_q <= REQ_I;
            REQ_O <= req_d;
            ACK_O <= ack_d;
            CMD_OE_O <= oe_d;
            CMD_OUT_O <= out_d;
            if (accept) begin
                cmd_q <= CMD_I;
                set_q <= SETTING_I[10:0];
                crc_bad <= 1'b0;
                CMD_O <= '0;
                STATUS_O <= 8'h01;
            end
            if (state == S_RX) CMD_O[7'(126 - cnt)] <= CMD_DAT_I;
            if (state == S_RX_CRC && cnt < 7 && CMD_DAT_I != crc[3'(6 - cnt)]) crc_bad <= 1'b1;
            if (state == S_TX && state_n == S_NCC_WAIT) begin
                STATUS_O[ST_RSP_DONE] <= 1'b1;
                STATUS_O[ST_CRC_OK] <= 1'b1;
            end
            if (state == S_WAIT_RSP && state_n == S_NCC_WAIT) STATUS_O[ST_TIMEOUT] <= 1'b1;
            if (state == S_RX_CRC && state_n == S_NCC_WAIT) begin
                STATUS_O[ST_RSP_DONE] <= 1'b1;
                STATUS_O[ST_CRC_OK] <= !crc_bad || !set_q[7];
                STATUS_O[ST_END_ERR] <= !CMD_DAT_I;
            end
            if ((state == S_NCC_WAIT && state_n == S_REPORT) || go) STATUS_O[ST_BUSY] <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sd_cmd_serial_host.sv
// tb_sd_cmd_serial_host: scoreboard bench with a behavioural SD card and CRC7 reference
module tb_sd_cmd_serial_host;
    typedef struct packed {
        logic [127:0] cmd;
        logic [7:0]   st;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  setting = '0;
    logic [39:0]  cmd_in = '0;
    logic         req_i = 1'b0;
    logic         ack_i = 1'b0;
    logic         go_idle = 1'b0;
    logic         cmd_dat = 1'b1;
    logic         req_o, ack_o, cmd_out, cmd_oe;
    logic [127:0] cmd_o;
    logic [7:0]   status_o;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic [47:0] frame_q[$];
    rsp_t rsp_q[$];
    logic [47:0] fbits = '0;
    int fn = 0;
    logic req_prev = 1'b0;

    sd_cmd_serial_host dut (
        .CLK_PAD_IO(clk),
        .RST_PAD_I (rst),
        .SETTING_I (setting),
        .CMD_I     (cmd_in),
        .REQ_I     (req_i),
        .ACK_I     (ack_i),
        .GO_IDLE_I (go_idle),
        .CMD_DAT_I (cmd_dat),
        .REQ_O     (req_o),
        .ACK_O     (ack_o),
        .CMD_O     (cmd_o),
        .STATUS_O  (status_o),
        .CMD_OUT_O (cmd_out),
        .CMD_OE_O  (cmd_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // CRC7 as the remainder of message*x^7 divided by x^7+x^3+1
    function automatic logic [6:0] crc7_ref(input logic [255:0] m, input int n);
        logic [255:0] r;
        r = m << 7;
        for (int i = n + 6; i >= 7; i--)
            if (r[i]) r = r ^ (256'h89 << (i - 7));
        return r[6:0];
    endfunction

    // what the master should see for a command with this setting and card reply
    function automatic rsp_t model(input logic [15:0] s, input logic respond, input logic [135:0] card);
        rsp_t r;
        logic [6:0] ce;
        r.cmd = '0;
        r.st = 8'h60;
        if (s[6:0] == 7'd0) return r;
        if (!respond) begin
            r.st = 8'h10;
            return r;
        end
        if (s[6:0] == 7'd39) begin
            r.cmd = {card[47:8], 88'b0};
            ce = crc7_ref({216'b0, card[47:8]}, 40);
        end else begin
            r.cmd = card[135:8];
            ce = crc7_ref({136'b0, card[127:8]}, 120);
        end
        r.st = 8'h40 | ((card[7:1] == ce || !s[7]) ? 8'h20 : 8'h00) | (!card[0] ? 8'h08 : 8'h00);
        return r;
    endfunction

    // pad monitor: collect each contiguous 48-bit driven frame and compare with the scoreboard
    always @(negedge clk) begin
        if (mon_en && cmd_oe) begin
            fbits = {fbits[46:0], cmd_out};
            fn++;
            if (fn == 48) begin
                fn = 0;
                if (frame_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_frame_unexpected: got %0h expected none", fbits);
                end else chk("tx_frame", {80'b0, fbits}, {80'b0, frame_q.pop_front()});
            end
        end else fn = 0;
    end

    // report monitor: compare response and status whenever REQ_O rises
    always @(negedge clk) begin
        if (req_o && !req_prev) begin
            if (rsp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL report_unexpected: got status %0h expected no report", status_o);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                chk("cmd_o", cmd_o, e.cmd);
                chk("status_o", {120'b0, status_o}, {120'b0, e.st});
            end
        end
        req_prev = req_o;
    end

    task automatic do_cmd(input logic [39:0] c, input logic [15:0] s, input logic respond,
                          input logic flip, input logic endbad, input int gap, input logic [47:0] fr_over);
        logic [135:0] card;
        logic [127:0] m128;
        logic [39:0] m40;
        logic [6:0] cr, fm;
        int len, k, lat;
        logic oe_seen;
        card = '0;
        len = 0;
        fm = flip ? 7'(1 << $urandom_range(0, 6)) : 7'd0;
        if (s[6:0] == 7'd39) begin
            m40 = {2'b00, c[37:32], c[31:0]};
            cr = crc7_ref({216'b0, m40}, 40) ^ fm;
            card = {88'b0, m40, cr, !endbad};
            len = 48;
        end else if (s[6:0] == 7'd127) begin
            m128 = {2'b00, 6'h3f, 24'($urandom), $urandom, $urandom, $urandom};
            cr = crc7_ref({136'b0, m128[119:0]}, 120) ^ fm;
            card = {m128, cr, !endbad};
            len = 136;
        end
        frame_q.push_back(fr_over != 0 ? fr_over : {c, crc7_ref({216'b0, c}, 40), 1'b1});
        rsp_q.push_back(model(s, respond && len != 0, card));
        @(negedge clk);
        cmd_in = c;
        setting = s;
        req_i = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!cmd_oe && lat < 30);
        chk("tx_start_latency", 128'(lat), 128'(3 + s[10:8]));
        k = 0;
        while (cmd_oe && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("tx_oe_release", {127'b0, cmd_oe}, 128'd0);
        if (respond && len != 0) begin
            repeat (gap) @(negedge clk);
            for (int i = len - 1; i >= 0; i--) begin
                cmd_dat = card[i];
                @(negedge clk);
            end
            cmd_dat = 1'b1;
        end
        k = 0;
        while (!req_o && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("req_o_raised", {127'b0, req_o}, 128'd1);
        ack_i = 1'b1;
        k = 0;
        while (req_o && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("req_o_dropped", {127'b0, req_o}, 128'd0);
        ack_i = 1'b0;
        oe_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            oe_seen |= cmd_oe;
        end
        chk("no_retrigger_held_req", {127'b0, oe_seen}, 128'd0);
        chk("ack_o_idle", {127'b0, ack_o}, 128'd1);
        req_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic bad;
        int k;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {cmd_o[125:0], req_o, ack_o}, 128'd0);
        chk("reset_status", {120'b0, status_o}, 128'd0);
        chk("reset_pad", {126'b0, cmd_out, cmd_oe}, 128'd3);
        rst = 1'b0;
        bad = 1'b0;
        repeat (80) begin
            @(negedge clk);
            bad |= !cmd_oe || !cmd_out || ack_o;
        end
        chk("init_hold_cmd_high", {127'b0, bad}, 128'd0);
        k = 0;
        while (!ack_o && k < 5) begin
            @(negedge clk);
            k++;
        end
        chk("init_done_ack", {127'b0, ack_o}, 128'd1);
        chk("init_done_oe", {127'b0, cmd_oe}, 128'd0);
        mon_en = 1'b1;

        do_cmd(40'h40_0000_0000, 16'h0080, 1'b0, 1'b0, 1'b0, 0, 48'h4000_0000_0095);
        do_cmd(40'h51_0000_0900, 16'h00a7, 1'b1, 1'b0, 1'b0, 3, '0);
        do_cmd(40'h51_0000_0900, 16'h00a7, 1'b1, 1'b1, 1'b0, 5, '0);
        do_cmd(40'h51_0000_0900, 16'h0027, 1'b1, 1'b1, 1'b0, 2, '0);
        do_cmd(40'h42_0000_0000, 16'h00ff, 1'b1, 1'b0, 1'b0, 4, '0);
        do_cmd(40'h49_1234_0000, 16'h07a7, 1'b0, 1'b0, 1'b0, 0, '0);

        @(negedge clk);
        cmd_in = 40'h4d_abcd_0000;
        setting = 16'h00a7;
        req_i = 1'b1;
        k = 0;
        while (!cmd_oe && k < 20) begin
            @(negedge clk);
            k++;
        end
        repeat (20) @(negedge clk);
        go_idle = 1'b1;
        @(negedge clk);
        chk("go_idle_oe", {127'b0, cmd_oe}, 128'd0);
        go_idle = 1'b0;
        req_i = 1'b0;
        k = 0;
        while (!ack_o && k < 5) begin
            @(negedge clk);
            k++;
        end
        chk("go_idle_ack", {127'b0, ack_o}, 128'd1);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            bad |= req_o || cmd_oe;
        end
        chk("go_idle_quiet", {127'b0, bad}, 128'd0);
        do_cmd(40'h4d_abcd_0000, 16'h00a7, 1'b1, 1'b0, 1'b0, 1, '0);

        for (int n = 0; n < 20; n++) begin
            logic [6:0] sz;
            logic [15:0] s;
            logic [39:0] c;
            k = $urandom_range(0, 2);
            sz = k == 0 ? 7'd0 : k == 1 ? 7'd39 : 7'd127;
            s = {5'b0, 3'($urandom_range(0, 7)), 1'($urandom), sz};
            c = {2'b01, 6'($urandom), $urandom};
            do_cmd(c, s, $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 5) == 0, $urandom_range(0, 30), '0);
        end

        repeat (5) @(negedge clk);
        chk("frame_queue_drained", 128'(frame_q.size()), 128'd0);
        chk("rsp_queue_drained", 128'(rsp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of run expected finish");
        $fatal(1);
    end
endmodule
